vga_display_timings: RTL and testbench
======================================

// Module: vga_display_timings
// PURPOSE
//  Raster timing generator for a VGA video controller: free-running horizontal/vertical pixel counters
//  produce hsync, vsync, data-enable and the current pixel coordinates. Default is 640x480@60 (25.175 MHz
//  nominal pixel clock). Pixel-data pipelines and sync-driven logic (e.g. cursor blink on vsync) consume it.
// PARAMETERS
//  CORDW     10   width of sx/sy coordinate outputs
//  H_RES     640  active pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   horizontal sync width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_RES     480  active lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vertical sync width (lines)
//  V_BP      33   vertical back porch (lines)
//  H_POL     0    hsync active level (0 = active-low)
//  V_POL     0    vsync active level (0 = active-low)
// PORTS
//  clk_pix  in   1      pixel clock; only clock
//  rst      in   1      reset, synchronous and active-high
//  hsync    out  1      horizontal sync, active level per H_POL
//  vsync    out  1      vertical sync, active level per V_POL
//  de       out  1      data enable, high in active area
//  sx       out  CORDW  current column, 0..H_TOTAL-1
//  sy       out  CORDW  current line, 0..V_TOTAL-1
// BEHAVIOUR
//  - H_TOTAL = H_RES+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_RES+V_FP+V_SYNC+V_BP (525).
//  - sx/sy are registers. Each clk_pix edge: sx increments. At sx==H_TOTAL-1, sx wraps to 0 and sy
//    increments. At sx==H_TOTAL-1 and sy==V_TOTAL-1, both wrap to 0 (frame wrap).
//  - Coordinate 0,0 is the first active pixel. Order per line: active, front porch, sync, back porch.
//  - de = (sx < H_RES) && (sy < V_RES); combinational from the sx/sy registers, same cycle.
//  - hsync active when H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC (656..751).
//  - vsync active when V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC (490..491), for whole lines.
//  - hsync/vsync are registered, so they lag sx/sy by one clock. Their inactive level is applied at reset.
//  - Reset: while rst is high at an edge, sx=0, sy=0, hsync=vsync=inactive. de is forced 0 while rst=1.
//    First cycle after reset release shows sx=0, sy=0, de=1.
//  - Reset mid-frame is legal: counters restart at 0,0 on the next edge.
//  - No other inputs; counters never stall. All arithmetic is unsigned CORDW bits. Parameters must give
//    H_TOTAL and V_TOTAL <= 2^CORDW.
// CONFIGURATION
//  DISPLAY_TIMINGS_FRAME_PULSE_EN: when defined, adds outputs line_start (1 clk high when sx==0) and
//  frame_start (1 clk high when sx==0 && sy==0), both combinational from the counters and forced 0 during
//  rst. When undefined, these ports are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package vga_timing_pkg: 640x480@60 timing constants (H_/V_ RES/FP/SYNC/BP) and the derived
//    H_TOTAL/V_TOTAL values.
//  - Single flat module; no sub-module. Only the two counters, the sync registers and the de decode.
// TESTING
//  1 rst high 3 clks, then low -> first cycle sx=0, sy=0, de=1; hsync=vsync=1 (inactive, active-low).
//  2 Run one line -> de high for sx 0..639, low for 640..799; hsync low for exactly 96 clks,
//    one clock after sx==656.
//  3 Line wrap: at sx=799, sy=5 -> next clk sx=0, sy=6.
//  4 Frame wrap: sx=799, sy=524 -> next clk sx=0, sy=0; frame length is exactly 420000 clks.
//  5 vsync low exactly 2*800=1600 clks per frame, during sy 490..491 (lagged 1 clk); de=0 for sy>=480.
//  6 Assert rst at sx=300, sy=200 for 1 clk -> sx=0, sy=0, syncs inactive; with the macro defined,
//    frame_start pulses on the release cycle.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared raster timing constants for the 640x480@60 video
//                mode (25.175 MHz nominal pixel clock) and the derived
//                line/frame totals.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

   // Horizontal timing, in pixels
   localparam int c_H_RES  = 640;
   localparam int c_H_FP   = 16;
   localparam int c_H_SYNC = 96;
   localparam int c_H_BP   = 48;

   // Vertical timing, in lines
   localparam int c_V_RES  = 480;
   localparam int c_V_FP   = 10;
   localparam int c_V_SYNC = 2;
   localparam int c_V_BP   = 33;

   // Totals: 800 pixels per line, 525 lines per frame
   localparam int c_H_TOTAL = c_H_RES + c_H_FP + c_H_SYNC + c_H_BP;
   localparam int c_V_TOTAL = c_V_RES + c_V_FP + c_V_SYNC + c_V_BP;

endpackage
`default_nettype wire

// File: rtl/vga_display_timings.sv
`default_nettype none
// ============================================================================
//  Module      : vga_display_timings
//  Description : Free-running raster timing generator. Column/line counters
//                drive registered hsync/vsync (one clock behind sx/sy) and a
//                combinational data-enable. Defaults give 640x480@60.
//                Optional macro DISPLAY_TIMINGS_FRAME_PULSE_EN adds the
//                line_start / frame_start strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_display_timings
   import vga_timing_pkg::*;
#(
   parameter int CORDW  = 10,
   parameter int H_RES  = c_H_RES,
   parameter int H_FP   = c_H_FP,
   parameter int H_SYNC = c_H_SYNC,
   parameter int H_BP   = c_H_BP,
   parameter int V_RES  = c_V_RES,
   parameter int V_FP   = c_V_FP,
   parameter int V_SYNC = c_V_SYNC,
   parameter int V_BP   = c_V_BP,
   parameter bit H_POL  = 1'b0,
   parameter bit V_POL  = 1'b0
) (
   input  logic             clk_pix,
   input  logic             rst,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
`ifdef DISPLAY_TIMINGS_FRAME_PULSE_EN
   output logic             line_start,
   output logic             frame_start,
`endif
   output logic [CORDW-1:0] sx,
   output logic [CORDW-1:0] sy
);

   localparam int c_H_TOT = H_RES + H_FP + H_SYNC + H_BP;
   localparam int c_V_TOT = V_RES + V_FP + V_SYNC + V_BP;

   // Counter limits and decode boundaries, all in CORDW-bit unsigned space.
   // Sync windows use inclusive last positions so a zero back porch with a
   // full 2^CORDW total never needs an out-of-range constant.
   localparam logic [CORDW-1:0] c_ONE     = CORDW'(1);
   localparam logic [CORDW-1:0] c_H_LAST  = CORDW'(c_H_TOT - 1);
   localparam logic [CORDW-1:0] c_V_LAST  = CORDW'(c_V_TOT - 1);
   localparam logic [CORDW-1:0] c_H_ACT   = CORDW'(H_RES);
   localparam logic [CORDW-1:0] c_V_ACT   = CORDW'(V_RES);
   localparam logic [CORDW-1:0] c_HS_BEG  = CORDW'(H_RES + H_FP);
   localparam logic [CORDW-1:0] c_HS_LAST = CORDW'(H_RES + H_FP + H_SYNC - 1);
   localparam logic [CORDW-1:0] c_VS_BEG  = CORDW'(V_RES + V_FP);
   localparam logic [CORDW-1:0] c_VS_LAST = CORDW'(V_RES + V_FP + V_SYNC - 1);

   // Totals must fit in the coordinate width or the counters alias.
   if ((c_H_TOT > (2 ** CORDW)) || (c_V_TOT > (2 ** CORDW))) begin : g_cordw_check
      $error("vga_display_timings: H/V total exceeds 2**CORDW");
   end

   logic w_line_last;
   logic w_frame_last;
   logic w_hs_act;
   logic w_vs_act;

   assign w_line_last  = (sx == c_H_LAST);
   assign w_frame_last = w_line_last && (sy == c_V_LAST);
   assign w_hs_act     = (sx >= c_HS_BEG) && (sx <= c_HS_LAST);
   assign w_vs_act     = (sy >= c_VS_BEG) && (sy <= c_VS_LAST);

   // Column/line counters: sx wraps every line, sy advances on each wrap and
   // both return to the first active pixel at the end of the frame.
   always_ff @(posedge clk_pix) begin
      if (rst) begin
         sx <= '0;
         sy <= '0;
      end else if (w_frame_last) begin
         sx <= '0;
         sy <= '0;
      end else if (w_line_last) begin
         sx <= '0;
         sy <= sy + c_ONE;
      end else begin
         sx <= sx + c_ONE;
      end
   end

   // Sync outputs are decoded from the current count and registered, so they
   // trail sx/sy by one clock and stay glitch-free at the pins.
   always_ff @(posedge clk_pix) begin
      if (rst) begin
         hsync <= ~H_POL;
         vsync <= ~V_POL;
      end else begin
         hsync <= w_hs_act ? H_POL : ~H_POL;
         vsync <= w_vs_act ? V_POL : ~V_POL;
      end
   end

   // Data enable is aligned with sx/sy (no register) and held low in reset.
   assign de = !rst && (sx < c_H_ACT) && (sy < c_V_ACT);

`ifdef DISPLAY_TIMINGS_FRAME_PULSE_EN
   // Start-of-line / start-of-frame strobes, aligned with sx/sy.
   assign line_start  = !rst && (sx == '0);
   assign frame_start = line_start && (sy == '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_display_timings.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_display_timings
//  Description : Bench for vga_display_timings. DUT A uses the default
//                640x480 mode; DUT B uses a tiny mode (25x17, active-high
//                syncs) so whole frames fit in a short run. Expected values
//                come from a model that maps elapsed pixel clocks since reset
//                to a raster position with plain modulo arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_display_timings;

   localparam int B_HR = 16, B_HF = 2, B_HW = 3, B_HB = 4;
   localparam int B_VR = 10, B_VF = 2, B_VW = 2, B_VB = 3;
   localparam int B_HT = B_HR + B_HF + B_HW + B_HB;   // 25
   localparam int B_VT = B_VR + B_VF + B_VW + B_VB;   // 17

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       de;
      logic       hs;
      logic       vs;
      logic       ls;
      logic       fs;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       hs_a, vs_a, de_a, ls_a, fs_a;
   logic [9:0] sx_a, sy_a;
   logic       hs_b, vs_b, de_b, ls_b, fs_b;
   logic [5:0] sx_b, sy_b;
   longint     n = 0;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   // Pixel clocks elapsed since the last reset edge.
   always @(posedge clk) begin
      if (rst) n <= 0;
      else     n <= n + 1;
   end

   vga_display_timings u_dut_a (
      .clk_pix     (clk),
      .rst         (rst),
      .hsync       (hs_a),
      .vsync       (vs_a),
      .de          (de_a),
`ifdef DISPLAY_TIMINGS_FRAME_PULSE_EN
      .line_start  (ls_a),
      .frame_start (fs_a),
`endif
      .sx          (sx_a),
      .sy          (sy_a)
   );

   vga_display_timings #(
      .CORDW (6),
      .H_RES (B_HR), .H_FP (B_HF), .H_SYNC (B_HW), .H_BP (B_HB),
      .V_RES (B_VR), .V_FP (B_VF), .V_SYNC (B_VW), .V_BP (B_VB),
      .H_POL (1'b1), .V_POL (1'b1)
   ) u_dut_b (
      .clk_pix     (clk),
      .rst         (rst),
      .hsync       (hs_b),
      .vsync       (vs_b),
      .de          (de_b),
`ifdef DISPLAY_TIMINGS_FRAME_PULSE_EN
      .line_start  (ls_b),
      .frame_start (fs_b),
`endif
      .sx          (sx_b),
      .sy          (sy_b)
   );

`ifndef DISPLAY_TIMINGS_FRAME_PULSE_EN
   assign ls_a = 1'b0;
   assign fs_a = 1'b0;
   assign ls_b = 1'b0;
   assign fs_b = 1'b0;
`endif

   // Raster model: position = elapsed clocks modulo frame size; syncs reflect
   // the position one clock earlier, inactive right after reset.
   function automatic exp_t model(input longint cnt, input logic r,
                                  input int hr, input int hf, input int hw, input int hb,
                                  input int vr, input int vf, input int vw, input int vb,
                                  input logic hp, input logic vp);
      exp_t   m;
      int     ht, vt, x, y, px, py;
      longint p;
      ht   = hr + hf + hw + hb;
      vt   = vr + vf + vw + vb;
      p    = cnt % longint'(ht * vt);
      x    = int'(p % ht);
      y    = int'(p / ht);
      m.x  = 10'(x);
      m.y  = 10'(y);
      m.de = !r && (x < hr) && (y < vr);
      m.ls = !r && (x == 0);
      m.fs = m.ls && (y == 0);
      if (cnt == 0) begin
         m.hs = !hp;
         m.vs = !vp;
      end else begin
         p    = (cnt - 1) % longint'(ht * vt);
         px   = int'(p % ht);
         py   = int'(p / ht);
         m.hs = (px >= hr + hf && px < hr + hf + hw) ? hp : !hp;
         m.vs = (py >= vr + vf && py < vr + vf + vw) ? vp : !vp;
      end
      return m;
   endfunction

   function automatic exp_t ea();
      return model(n, rst, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
   endfunction

   function automatic exp_t eb();
      return model(n, rst, B_HR, B_HF, B_HW, B_HB, B_VR, B_VF, B_VW, B_VB, 1'b1, 1'b1);
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({sx_a, sy_a, de_a, hs_a, vs_a} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL reset_hold_a: got %h required %h", {sx_a, sy_a, de_a, hs_a, vs_a},
                  {10'd0, 10'd0, 1'b0, 1'b1, 1'b1});
      end
      checks++;
      if ({sx_b, sy_b, de_b, hs_b, vs_b} !== {6'd0, 6'd0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_hold_b: got %h required 0", {sx_b, sy_b, de_b, hs_b, vs_b});
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({sx_a, sy_a, de_a, hs_a, vs_a} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL reset_release_a: got %h required %h", {sx_a, sy_a, de_a, hs_a, vs_a},
                  {10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
      end
`ifdef DISPLAY_TIMINGS_FRAME_PULSE_EN
      checks++;
      if ({ls_a, fs_a} !== 2'b11) begin
         errors++;
         $display("FAIL reset_release_pulses: got %b required 11", {ls_a, fs_a});
      end
`endif
   endtask

   task automatic test_line();
      exp_t e;
      int   de_cnt = 0, hs_cnt = 0, first_low = -1;
      for (int i = 0; i < 800; i++) begin
         e = ea();
         checks++;
         if ({sx_a, sy_a, de_a, hs_a, vs_a} !== {e.x, e.y, e.de, e.hs, e.vs}) begin
            errors++;
            $display("FAIL line_a n=%0d: got %h required %h", n, {sx_a, sy_a, de_a, hs_a, vs_a},
                     {e.x, e.y, e.de, e.hs, e.vs});
         end
`ifdef DISPLAY_TIMINGS_FRAME_PULSE_EN
         checks++;
         if ({ls_a, fs_a} !== {e.ls, e.fs}) begin
            errors++;
            $display("FAIL line_pulses n=%0d: got %b required %b", n, {ls_a, fs_a}, {e.ls, e.fs});
         end
`endif
         if (de_a === 1'b1) de_cnt++;
         if (hs_a === 1'b0) begin
            hs_cnt++;
            if (first_low < 0) first_low = int'(sx_a);
         end
         @(negedge clk);
      end
      checks++;
      if (de_cnt != 640) begin
         errors++;
         $display("FAIL line_de_count: got %0d required 640", de_cnt);
      end
      checks++;
      if (hs_cnt != 96) begin
         errors++;
         $display("FAIL line_hsync_width: got %0d required 96", hs_cnt);
      end
      checks++;
      if (first_low != 657) begin
         errors++;
         $display("FAIL line_hsync_start: got sx=%0d required 657", first_low);
      end
   endtask

   task automatic test_line_wrap();
      exp_t e;
      bit   hit = 0;
      for (int i = 0; i < 6000 && !hit; i++) begin
         e = ea();
         if (e.x == 10'd799 && e.y == 10'd5) hit = 1;
         else @(negedge clk);
      end
      checks++;
      if (!hit || {sx_a, sy_a} !== {10'd799, 10'd5}) begin
         errors++;
         $display("FAIL line_wrap_pre: got %0d,%0d required 799,5", sx_a, sy_a);
      end
      @(negedge clk);
      checks++;
      if ({sx_a, sy_a} !== {10'd0, 10'd6}) begin
         errors++;
         $display("FAIL line_wrap_post: got %0d,%0d required 0,6", sx_a, sy_a);
      end
   endtask

   task automatic test_frame_b();
      exp_t e;
      int   vs_cnt = 0, de_bad = 0, starts = 0, last_start = -1, wraps = 0;
      bit   at_last = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int i = 0; i < 3 * B_HT * B_VT; i++) begin
         e = eb();
         checks++;
         if ({4'd0, sx_b, 4'd0, sy_b, de_b, hs_b, vs_b} !== {e.x, e.y, e.de, e.hs, e.vs}) begin
            errors++;
            $display("FAIL frame_b n=%0d: got %h required %h", n,
                     {4'd0, sx_b, 4'd0, sy_b, de_b, hs_b, vs_b}, {e.x, e.y, e.de, e.hs, e.vs});
         end
`ifdef DISPLAY_TIMINGS_FRAME_PULSE_EN
         checks++;
         if ({ls_b, fs_b} !== {e.ls, e.fs}) begin
            errors++;
            $display("FAIL frame_b_pulses n=%0d: got %b required %b", n, {ls_b, fs_b}, {e.ls, e.fs});
         end
`endif
         if (at_last) begin
            wraps++;
            checks++;
            if ({sx_b, sy_b} !== 12'd0) begin
               errors++;
               $display("FAIL frame_wrap_b: got %0d,%0d required 0,0", sx_b, sy_b);
            end
         end
         at_last = (sx_b == 6'(B_HT - 1)) && (sy_b == 6'(B_VT - 1));
         if (vs_b === 1'b1) vs_cnt++;
         if (sy_b >= 6'(B_VR) && de_b !== 1'b0) de_bad++;
         if (sx_b == 6'd0 && sy_b == 6'd0) begin
            if (last_start >= 0) begin
               checks++;
               if (i - last_start != B_HT * B_VT) begin
                  errors++;
                  $display("FAIL frame_length_b: got %0d required %0d", i - last_start, B_HT * B_VT);
               end
            end
            last_start = i;
            starts++;
         end
         @(negedge clk);
      end
      checks++;
      if (starts != 3 || wraps != 2) begin
         errors++;
         $display("FAIL frame_starts_b: got %0d starts %0d wraps required 3 and 2", starts, wraps);
      end
      checks++;
      if (vs_cnt != 3 * B_VW * B_HT) begin
         errors++;
         $display("FAIL vsync_width_b: got %0d required %0d", vs_cnt, 3 * B_VW * B_HT);
      end
      checks++;
      if (de_bad != 0) begin
         errors++;
         $display("FAIL de_blank_b: got %0d active cycles in vblank required 0", de_bad);
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      bit   hit = 0;
      for (int i = 0; i < 6000 && !hit; i++) begin
         e = ea();
         if (e.x == 10'd700 && e.y == 10'd3) hit = 1;
         else @(negedge clk);
      end
      checks++;
      if (!hit || {sx_a, sy_a, hs_a} !== {10'd700, 10'd3, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset_pre: got %0d,%0d hs=%b required 700,3 hs=0", sx_a, sy_a, hs_a);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({sx_a, sy_a, de_a, hs_a, vs_a} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL mid_reset_hold: got %h required %h", {sx_a, sy_a, de_a, hs_a, vs_a},
                  {10'd0, 10'd0, 1'b0, 1'b1, 1'b1});
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({sx_a, sy_a, de_a, hs_a, vs_a} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL mid_reset_release: got %h required %h", {sx_a, sy_a, de_a, hs_a, vs_a},
                  {10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
      end
`ifdef DISPLAY_TIMINGS_FRAME_PULSE_EN
      checks++;
      if (fs_a !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_frame_start: got %b required 1", fs_a);
      end
`endif
   endtask

   task automatic test_random_reset();
      exp_t ma, mb;
      int   len, hold;
      for (int r = 0; r < 8; r++) begin
         len  = int'($urandom_range(1, 1500));
         hold = int'($urandom_range(1, 3));
         for (int i = 0; i < len; i++) begin
            @(negedge clk);
            ma = ea();
            mb = eb();
            checks++;
            if ({sx_a, sy_a, de_a, hs_a, vs_a} !== {ma.x, ma.y, ma.de, ma.hs, ma.vs}) begin
               errors++;
               $display("FAIL random_a n=%0d: got %h required %h", n,
                        {sx_a, sy_a, de_a, hs_a, vs_a}, {ma.x, ma.y, ma.de, ma.hs, ma.vs});
            end
            checks++;
            if ({4'd0, sx_b, 4'd0, sy_b, de_b, hs_b, vs_b} !== {mb.x, mb.y, mb.de, mb.hs, mb.vs}) begin
               errors++;
               $display("FAIL random_b n=%0d: got %h required %h", n,
                        {4'd0, sx_b, 4'd0, sy_b, de_b, hs_b, vs_b}, {mb.x, mb.y, mb.de, mb.hs, mb.vs});
            end
         end
         rst = 1'b1;
         repeat (hold) begin
            @(negedge clk);
            checks++;
            if ({sx_b, sy_b, de_b, hs_b, vs_b, de_a, ls_a, fs_a} !== 15'd0) begin
               errors++;
               $display("FAIL random_reset_hold: got %h required 0",
                        {sx_b, sy_b, de_b, hs_b, vs_b, de_a, ls_a, fs_a});
            end
         end
         rst = 1'b0;
         #1;
         checks++;
         if ({sx_b, sy_b, de_b, hs_b, vs_b} !== {6'd0, 6'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL random_release_b: got %h required %h", {sx_b, sy_b, de_b, hs_b, vs_b},
                     {6'd0, 6'd0, 1'b1, 1'b0, 1'b0});
         end
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_line_wrap();
      test_frame_b();
      test_mid_reset();
      test_random_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
